// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter in front of a single-port data memory: grants one requester,
// validates alignment/range, issues a one-cycle memory access and returns a response.
module dmem_access_arbiter #(
    parameter logic [31:0] ADDR_LO = 32'h0400_4000,
    parameter logic [31:0] ADDR_HI = 32'h7fff_ffff,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  req_wen,
    input  logic [3:0]  req_rwtype,
    input  logic [1:0]  req_sext,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [1:0]  mem_rwtype,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_sext,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; grant is combinational
    // ACCESS | memory strobes driven for one cycle (suppressed on error)
    // RESP   | response held until the owning port accepts it
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      state, state_nxt;
    logic        rr_pref;
    logic        own;
    logic        sel;
    logic        l_wen, l_sext;
    logic [1:0]  l_rwtype;
    logic [31:0] l_addr, l_wdata;
    logic        acc_err;

    // rr_pref is the port that wins a tie; it flips to the other port on every grant
    always_comb begin
        if (req == 2'b11)
            sel = RR_EN ? rr_pref : 1'b0;
        else
            sel = ~req[0];
    end

    always_comb begin
        acc_err = 1'b0;
        if (l_rwtype == 2'b01 && l_addr[0])
            acc_err = 1'b1;
        if (l_rwtype[1] && l_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        if (l_addr < ADDR_LO || l_addr > ADDR_HI)
            acc_err = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        gnt        = 2'b00;
        rsp_valid  = 2'b00;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_rwtype = 2'b00;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_sext   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req && !rst) begin
                    gnt       = sel ? 2'b10 : 2'b01;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = S_RESP;
                if (!acc_err) begin
                    mem_ren    = ~l_wen;
                    mem_wen    = l_wen;
                    mem_rwtype = l_rwtype;
                    mem_addr   = l_addr;
                    mem_wdata  = l_wdata;
                    mem_sext   = l_sext;
                end
            end
            S_RESP: begin
                rsp_valid = own ? 2'b10 : 2'b01;
                if (rsp_ready[own])
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_pref   <= 1'b0;
            own       <= 1'b0;
            l_wen     <= 1'b0;
            l_sext    <= 1'b0;
            l_rwtype  <= 2'b00;
            l_addr    <= 32'h0;
            l_wdata   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && |req) begin
                own      <= sel;
                rr_pref  <= ~sel;
                l_wen    <= sel ? req_wen[1]        : req_wen[0];
                l_sext   <= sel ? req_sext[1]       : req_sext[0];
                l_rwtype <= sel ? req_rwtype[3:2]   : req_rwtype[1:0];
                l_addr   <= sel ? req_addr[63:32]   : req_addr[31:0];
                l_wdata  <= sel ? req_wdata[63:32]  : req_wdata[31:0];
            end
            if (state == S_ACCESS) begin
                rsp_rdata <= (acc_err || l_wen) ? 32'h0 : mem_rdata;
                rsp_err   <= acc_err;
            end
            if (state == S_RESP && rsp_ready[own]) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a small byte-addressable memory model;
// a second fixed-priority instance shares the stimulus for the arbitration test.
module tb_dmem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_wen, req_sext, rsp_ready;
    logic [3:0]  req_rwtype;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        rsp_err, mem_ren, mem_wen, mem_sext;
    logic [1:0]  mem_rwtype;

    logic [1:0]  gnt_fp, rsp_valid_fp, mem_rwtype_fp;
    logic [31:0] rsp_rdata_fp, mem_addr_fp, mem_wdata_fp;
    logic        rsp_err_fp, mem_ren_fp, mem_wen_fp, mem_sext_fp;
    logic [31:0] mem_rdata_fp = 32'h0;

    int tests_run = 0;
    int fails = 0;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    always #5 clk = ~clk;

    dmem_access_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .req_wen(req_wen),
        .req_rwtype(req_rwtype), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_rwtype(mem_rwtype), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sext(mem_sext), .mem_rdata(mem_rdata)
    );

    dmem_access_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_fp), .req_wen(req_wen),
        .req_rwtype(req_rwtype), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_fp), .rsp_err(rsp_err_fp), .mem_ren(mem_ren_fp),
        .mem_wen(mem_wen_fp), .mem_rwtype(mem_rwtype_fp), .mem_addr(mem_addr_fp),
        .mem_wdata(mem_wdata_fp), .mem_sext(mem_sext_fp), .mem_rdata(mem_rdata_fp)
    );

    // memory model: 256-byte window at 0x0400_4000, little-endian, reads 0 elsewhere
    logic        in_win;
    logic [31:0] word, shifted;
    always_comb begin
        in_win    = (mem_addr[31:8] == 24'h040040);
        word      = in_win ? mem[mem_addr[7:2]] : 32'h0;
        shifted   = word >> {mem_addr[1:0], 3'b000};
        mem_rdata = 32'h0;
        case (mem_rwtype)
            2'b00:   mem_rdata = mem_sext ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
            2'b01:   mem_rdata = mem_sext ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            default: mem_rdata = word;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wen && in_win) begin
            case (mem_rwtype)
                2'b00:   mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8]  <= mem_wdata[7:0];
                2'b01:   mem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[7:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic txn(input int p, input logic wen, input logic [1:0] rw, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int nren, output int nwen, output int lat);
        int cyc;
        nren = 0; nwen = 0; lat = 0; rdata = 32'h0; err = 1'b0;
        @(negedge clk);
        req_wen[p] = wen;
        req_rwtype[2*p +: 2] = rw;
        req_sext[p] = sext;
        req_addr[32*p +: 32] = addr;
        req_wdata[32*p +: 32] = wdata;
        req[p] = 1'b1;
        #1;
        cyc = 0;
        while (gnt[p] !== 1'b1 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        if (gnt[p] !== 1'b1) begin
            tests_run++; fails++;
            $display("FAIL txn_gnt_timeout port=%0d got gnt=%b want bit set", p, gnt);
            req[p] = 1'b0;
            return;
        end
        @(negedge clk);
        req[p] = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            nren += int'(mem_ren);
            nwen += int'(mem_wen);
            lat++;
            if (rsp_valid[p] === 1'b1) break;
            @(negedge clk); cyc++;
        end
        if (rsp_valid[p] !== 1'b1) begin
            tests_run++; fails++;
            $display("FAIL txn_rsp_timeout port=%0d got rsp_valid=%b", p, rsp_valid);
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready[p] = 1'b1;
        @(negedge clk);
        nren += int'(mem_ren);
        nwen += int'(mem_wen);
        rsp_ready[p] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 2'b11;
        #1;
        tests_run++;
        if ({gnt, gnt_fp, rsp_valid, mem_ren, mem_wen} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got %b want 0", {gnt, gnt_fp, rsp_valid, mem_ren, mem_wen});
        end
        tests_run++;
        if ({rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rwtype, mem_sext} !== 100'h0) begin
            fails++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h", rsp_rdata, mem_addr, mem_wdata);
        end
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int nr, nw, lat;
        txn(0, 1'b1, 2'b10, 1'b0, 32'h0400_4000, 32'hDEAD_BEEF, rd, er, nr, nw, lat);
        tests_run++;
        if ({er, rd} !== 33'h0) begin fails++; $display("FAIL st_rsp got err=%b rdata=%h want 0/0", er, rd); end
        tests_run++;
        if (nw !== 1 || nr !== 0) begin fails++; $display("FAIL st_strobes got wen=%0d ren=%0d want 1/0", nw, nr); end
        tests_run++;
        if (lat !== 2) begin fails++; $display("FAIL st_latency got %0d want 2", lat); end
        tests_run++;
        if (mem[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL st_mem got %h want deadbeef", mem[0]); end
        txn(0, 1'b0, 2'b10, 1'b0, 32'h0400_4000, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin fails++; $display("FAIL ld_word got rdata=%h err=%b want deadbeef/0", rd, er); end
        tests_run++;
        if (nr !== 1 || nw !== 0) begin fails++; $display("FAIL ld_strobes got ren=%0d wen=%0d want 1/0", nr, nw); end
    endtask

    task automatic test_byte_sext;
        logic [31:0] rd; logic er; int nr, nw, lat;
        txn(1, 1'b0, 2'b00, 1'b1, 32'h0400_4003, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (rd !== 32'hFFFF_FFDE || er !== 1'b0) begin fails++; $display("FAIL byte_sext got %h want ffffffde", rd); end
        txn(1, 1'b0, 2'b00, 1'b0, 32'h0400_4003, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (rd !== 32'h0000_00DE || er !== 1'b0) begin fails++; $display("FAIL byte_zext got %h want 000000de", rd); end
    endtask

    task automatic test_arbitration;
        logic [1:0] got [0:3];
        logic [1:0] got_fp [0:3];
        int n, cyc;
        @(negedge clk);
        req_wen = 2'b00; req_rwtype = 4'b1010; req_sext = 2'b00;
        req_addr = {32'h0400_4000, 32'h0400_4000};
        req_wdata = 64'h0;
        rsp_ready = 2'b11;
        req = 2'b11;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            #1;
            if (gnt !== 2'b00) begin got[n] = gnt; got_fp[n] = gnt_fp; n++; end
            @(negedge clk); cyc++;
        end
        tests_run++;
        if (n !== 4) begin fails++; $display("FAIL rr_count got %0d grants want 4", n); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (got[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL rr_grant[%0d] got %b want %b", i, got[i], (i % 2 == 1) ? 2'b10 : 2'b01);
                end
                tests_run++;
                if (got_fp[i] !== 2'b01) begin
                    fails++; $display("FAIL fp_grant[%0d] got %b want 01", i, got_fp[i]);
                end
            end
        end
        req[0] = 1'b0;
        cyc = 0;
        #1;
        while (gnt_fp === 2'b00 && cyc < 10) begin @(negedge clk); #1; cyc++; end
        tests_run++;
        if (gnt_fp !== 2'b10) begin fails++; $display("FAIL fp_only_p1 got %b want 10", gnt_fp); end
        @(negedge clk);
        req = 2'b00;
        repeat (4) @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int nr, nw, lat;
        txn(0, 1'b0, 2'b01, 1'b0, 32'h0400_4001, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL err_half_mis got err=%b rdata=%h want 1/0", er, rd); end
        tests_run++;
        if (nr !== 0 || nw !== 0) begin fails++; $display("FAIL err_half_strobes got ren=%0d wen=%0d want 0/0", nr, nw); end
        txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'h0 || nr !== 0) begin fails++; $display("FAIL err_low_addr got err=%b rdata=%h ren=%0d want 1/0/0", er, rd, nr); end
        txn(0, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b1 || nw !== 0) begin fails++; $display("FAIL err_high_addr got err=%b wen=%0d want 1/0", er, nw); end
        txn(0, 1'b0, 2'b00, 1'b0, 32'h0400_3FFF, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b1 || nr !== 0) begin fails++; $display("FAIL err_below_lo got err=%b ren=%0d want 1/0", er, nr); end
        txn(1, 1'b0, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b0 || nr !== 1) begin fails++; $display("FAIL ok_at_hi got err=%b ren=%0d want 0/1", er, nr); end
        txn(0, 1'b0, 2'b01, 1'b0, 32'h0400_4002, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (er !== 1'b0 || rd !== 32'h0000_DEAD) begin fails++; $display("FAIL half_upper got err=%b rdata=%h want 0/0000dead", er, rd); end
    endtask

    task automatic test_backpressure;
        int cyc;
        @(negedge clk);
        req_wen = 2'b00; req_rwtype = 4'b1010; req_sext = 2'b00;
        req_addr = {32'h0400_4000, 32'h0400_4000};
        req = 2'b01;
        #1;
        cyc = 0;
        while (gnt[0] !== 1'b1 && cyc < 10) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        req = 2'b10;
        rsp_ready = 2'b10;
        cyc = 0;
        while (rsp_valid[0] !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF || gnt !== 2'b00) begin
                fails++; $display("FAIL stall[%0d] got valid=%b rdata=%h gnt=%b want 01/deadbeef/00", i, rsp_valid, rsp_rdata, gnt);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        tests_run++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || gnt !== 2'b10) begin
            fails++; $display("FAIL after_hs got valid=%b rdata=%h gnt=%b want 00/0/10", rsp_valid, rsp_rdata, gnt);
        end
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL pending_p1 got valid=%b rdata=%h want 10/deadbeef", rsp_valid, rsp_rdata);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int nr, nw, lat, cyc;
        @(negedge clk);
        req_wen[0] = 1'b1; req_rwtype[1:0] = 2'b10; req_sext[0] = 1'b0;
        req_addr[31:0] = 32'h0400_4004; req_wdata[31:0] = 32'h1234_5678;
        req[0] = 1'b1;
        #1;
        cyc = 0;
        while (gnt[0] !== 1'b1 && cyc < 10) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        req[0] = 1'b0;
        tests_run++;
        if (mem_wen !== 1'b1) begin fails++; $display("FAIL mid_pre_wen got %b want 1", mem_wen); end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mem_wen, mem_ren, gnt, rsp_valid, rsp_err} !== 7'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++; $display("FAIL mid_outputs got wen=%b addr=%h wdata=%h valid=%b", mem_wen, mem_addr, mem_wdata, rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if (mem[1] !== 32'h0) begin fails++; $display("FAIL mid_mem got %h want 0", mem[1]); end
        rst = 1'b0;
        txn(0, 1'b0, 2'b10, 1'b0, 32'h0400_4004, 32'h0, rd, er, nr, nw, lat);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b0 || nr !== 1) begin fails++; $display("FAIL mid_reload got rdata=%h err=%b ren=%0d want 0/0/1", rd, er, nr); end
        txn(1, 1'b1, 2'b10, 1'b0, 32'h0400_4004, 32'hCAFE_F00D, rd, er, nr, nw, lat);
        tests_run++;
        if (mem[1] !== 32'hCAFE_F00D || er !== 1'b0) begin fails++; $display("FAIL post_store got mem=%h err=%b want cafef00d/0", mem[1], er); end
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00; req_wen = 2'b00; req_sext = 2'b00; rsp_ready = 2'b00;
        req_rwtype = 4'h0; req_addr = 64'h0; req_wdata = 64'h0;
        repeat (2) @(negedge clk);
        test_reset;
        test_store_load;
        test_byte_sext;
        test_arbitration;
        test_errors;
        test_backpressure;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
